// File: rtl/core.sv
// ---------------------------------------------------------------------------------------------
// core: non-pipelined MIPS32 subset processor (FETCH -> EXEC -> (MEM) -> FETCH).
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   inst_addr_o            fetch address (PC)
//   inst_data_i/valid_i    instruction word and its valid strobe
//   data_addr_o            load/store byte address (valid in MEM)
//   data_data_i/o          load data in / store data out, both right-aligned
//   data_sel_o             access size 00 byte, 01 half, 10 word
//   data_we_o/rd_o         store / load request, held until data_valid_i
//   mem_fc, mem_sc         high in FETCH / MEM state
//   hw_page_fault          aborts a fetch or data access, cause = hw_cause
//   hw_interrupt           taken between instructions, cause = hw_cause
//   exception/cause/epc    one-cycle exception report
//   eret                   one-cycle ERET pulse
//   cp0_*                  external CP0 register file port
//   cp0_exception_base     exception vector address
//
// Build option
//   CORE_SUBWORD_EN        enables LB/LBU/LH/LHU/SB/SH; otherwise they raise cause 10.
// ---------------------------------------------------------------------------------------------
module core (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_data_i,
    input  logic        inst_valid_i,
    output logic [31:0] data_addr_o,
    input  logic [31:0] data_data_i,
    output logic [31:0] data_data_o,
    output logic [1:0]  data_sel_o,
    output logic        data_we_o,
    output logic        data_rd_o,
    input  logic        data_valid_i,
    output logic        mem_fc,
    output logic        mem_sc,
    input  logic        hw_page_fault,
    input  logic        hw_interrupt,
    input  logic [31:0] hw_cause,
    output logic        exception,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        eret,
    output logic [4:0]  cp0_addr_o,
    input  logic [31:0] cp0_data_i,
    output logic [31:0] cp0_data_o,
    output logic        cp0_we_o,
    input  logic [31:0] cp0_exception_base
);

    localparam logic [31:0] CauseAdel = 32'd4;
    localparam logic [31:0] CauseAdes = 32'd5;
    localparam logic [31:0] CauseSys  = 32'd8;
    localparam logic [31:0] CauseRi   = 32'd10;

    typedef enum logic [1:0] {StFetch, StExec, StMem} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] rf_q [32];

    // Access descriptor captured in EXEC and replayed on the bus during MEM.
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_sel_q, mem_sel_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_rd_q, mem_rd_d;
    logic [4:0]  mem_rt_q, mem_rt_d;
    logic        mem_unsigned_q, mem_unsigned_d;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        exc;
    logic [31:0] exc_cause;
    logic        instr_exc;
    logic [31:0] instr_cause;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val;
    logic [31:0] imm_sext, imm_zext;
    logic [31:0] pc_plus4, br_target, ea;
    logic [31:0] load_ext;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign rs_val   = rf_q[rs];
    assign rt_val   = rf_q[rt];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    assign pc_plus4 = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign ea       = rs_val + imm_sext;

    // Load data arrives right-aligned; extend according to the access size.
    always_comb begin
        load_ext = data_data_i;
        unique case (mem_sel_q)
            2'b00:   load_ext = mem_unsigned_q ? {24'h0, data_data_i[7:0]}
                                               : {{24{data_data_i[7]}}, data_data_i[7:0]};
            2'b01:   load_ext = mem_unsigned_q ? {16'h0, data_data_i[15:0]}
                                               : {{16{data_data_i[15]}}, data_data_i[15:0]};
            default: load_ext = data_data_i;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_sel_d      = mem_sel_q;
        mem_we_d       = mem_we_q;
        mem_rd_d       = mem_rd_q;
        mem_rt_d       = mem_rt_q;
        mem_unsigned_d = mem_unsigned_q;
        rf_we          = 1'b0;
        rf_waddr       = 5'd0;
        rf_wdata       = 32'h0;
        exc            = 1'b0;
        exc_cause      = 32'h0;
        instr_exc      = 1'b0;
        instr_cause    = 32'h0;
        eret           = 1'b0;
        cp0_addr_o     = 5'd0;
        cp0_data_o     = 32'h0;
        cp0_we_o       = 1'b0;

        unique case (state_q)
            StFetch: begin
                // Page fault outranks interrupt; both carry the external cause code.
                if (hw_page_fault || hw_interrupt) begin
                    exc       = 1'b1;
                    exc_cause = hw_cause;
                end else if (inst_valid_i) begin
                    ir_d    = inst_data_i;
                    state_d = StExec;
                end
            end

            StExec: begin
                pc_d    = pc_plus4;
                state_d = StFetch;
                case (opcode)
                    6'h00: begin
                        rf_waddr = rd;
                        case (funct)
                            6'h00: begin rf_we = 1'b1; rf_wdata = rt_val << shamt; end
                            6'h02: begin rf_we = 1'b1; rf_wdata = rt_val >> shamt; end
                            6'h03: begin rf_we = 1'b1; rf_wdata = $signed(rt_val) >>> shamt; end
                            6'h08, 6'h09: begin
                                if (rs_val[1:0] != 2'b00) begin
                                    instr_exc   = 1'b1;
                                    instr_cause = CauseAdel;
                                end else begin
                                    pc_d     = rs_val;
                                    rf_we    = funct[0];
                                    rf_wdata = pc_plus4;
                                end
                            end
                            6'h0C: begin instr_exc = 1'b1; instr_cause = CauseSys; end
                            6'h20, 6'h21: begin rf_we = 1'b1; rf_wdata = rs_val + rt_val; end
                            6'h23: begin rf_we = 1'b1; rf_wdata = rs_val - rt_val; end
                            6'h24: begin rf_we = 1'b1; rf_wdata = rs_val & rt_val; end
                            6'h25: begin rf_we = 1'b1; rf_wdata = rs_val | rt_val; end
                            6'h26: begin rf_we = 1'b1; rf_wdata = rs_val ^ rt_val; end
                            6'h27: begin rf_we = 1'b1; rf_wdata = ~(rs_val | rt_val); end
                            6'h2A: begin
                                rf_we    = 1'b1;
                                rf_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
                            end
                            6'h2B: begin rf_we = 1'b1; rf_wdata = {31'h0, rs_val < rt_val}; end
                            default: begin instr_exc = 1'b1; instr_cause = CauseRi; end
                        endcase
                    end
                    6'h02: pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                    6'h03: begin
                        pc_d     = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_plus4;
                    end
                    6'h04: if (rs_val == rt_val) pc_d = br_target;
                    6'h05: if (rs_val != rt_val) pc_d = br_target;
                    6'h08, 6'h09: begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = ea; end
                    6'h0A: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt;
                        rf_wdata = {31'h0, $signed(rs_val) < $signed(imm_sext)};
                    end
                    6'h0B: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt;
                        rf_wdata = {31'h0, rs_val < imm_sext};
                    end
                    6'h0C: begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = rs_val & imm_zext; end
                    6'h0D: begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = rs_val | imm_zext; end
                    6'h0E: begin rf_we = 1'b1; rf_waddr = rt; rf_wdata = rs_val ^ imm_zext; end
                    6'h0F: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt;
                        rf_wdata = {ir_q[15:0], 16'h0000};
                    end
                    6'h10: begin
                        if (ir_q[25] && funct == 6'h18) begin
                            // ERET: return address comes from EPC (CP0 r14).
                            cp0_addr_o = 5'd14;
                            pc_d       = cp0_data_i;
                            eret       = 1'b1;
                        end else if (rs == 5'd0) begin
                            cp0_addr_o = rd;
                            rf_we      = 1'b1;
                            rf_waddr   = rt;
                            rf_wdata   = cp0_data_i;
                        end else if (rs == 5'd4) begin
                            cp0_addr_o = rd;
                            cp0_data_o = rt_val;
                            cp0_we_o   = 1'b1;
                        end else begin
                            instr_exc   = 1'b1;
                            instr_cause = CauseRi;
                        end
                    end
                    6'h23, 6'h2B: begin
                        if (ea[1:0] != 2'b00) begin
                            instr_exc   = 1'b1;
                            instr_cause = opcode[3] ? CauseAdes : CauseAdel;
                        end else begin
                            mem_addr_d     = ea;
                            mem_wdata_d    = rt_val;
                            mem_sel_d      = 2'b10;
                            mem_we_d       = opcode[3];
                            mem_rd_d       = ~opcode[3];
                            mem_rt_d       = rt;
                            mem_unsigned_d = 1'b0;
                            pc_d           = pc_q;
                            state_d        = StMem;
                        end
                    end
`ifdef CORE_SUBWORD_EN
                    // opcode[0] selects half vs byte, opcode[2] zero-extension, opcode[3] store.
                    6'h20, 6'h21, 6'h24, 6'h25, 6'h28, 6'h29: begin
                        if (opcode[0] && ea[0]) begin
                            instr_exc   = 1'b1;
                            instr_cause = opcode[3] ? CauseAdes : CauseAdel;
                        end else begin
                            mem_addr_d     = ea;
                            mem_wdata_d    = opcode[0] ? {16'h0000, rt_val[15:0]}
                                                       : {24'h0, rt_val[7:0]};
                            mem_sel_d      = {1'b0, opcode[0]};
                            mem_we_d       = opcode[3];
                            mem_rd_d       = ~opcode[3];
                            mem_rt_d       = rt;
                            mem_unsigned_d = opcode[2];
                            pc_d           = pc_q;
                            state_d        = StMem;
                        end
                    end
`endif
                    default: begin instr_exc = 1'b1; instr_cause = CauseRi; end
                endcase

                // A faulting instruction must leave no architectural side effects.
                if (instr_exc) begin
                    exc        = 1'b1;
                    exc_cause  = instr_cause;
                    rf_we      = 1'b0;
                    eret       = 1'b0;
                    cp0_addr_o = 5'd0;
                    cp0_data_o = 32'h0;
                    cp0_we_o   = 1'b0;
                end
            end

            StMem: begin
                if (hw_page_fault) begin
                    exc       = 1'b1;
                    exc_cause = hw_cause;
                end else if (data_valid_i) begin
                    if (mem_rd_q) begin
                        rf_we    = 1'b1;
                        rf_waddr = mem_rt_q;
                        rf_wdata = load_ext;
                    end
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                end
            end

            default: state_d = StFetch;
        endcase

        if (exc) begin
            pc_d    = cp0_exception_base;
            state_d = StFetch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StFetch;
            pc_q           <= 32'h0;
            ir_q           <= 32'h0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            mem_sel_q      <= 2'b10;
            mem_we_q       <= 1'b0;
            mem_rd_q       <= 1'b0;
            mem_rt_q       <= 5'd0;
            mem_unsigned_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_sel_q      <= mem_sel_d;
            mem_we_q       <= mem_we_d;
            mem_rd_q       <= mem_rd_d;
            mem_rt_q       <= mem_rt_d;
            mem_unsigned_q <= mem_unsigned_d;
        end
    end

    // r0 is never written, so it reads as zero without a read-side mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign inst_addr_o = pc_q;
    assign mem_fc      = (state_q == StFetch);
    assign mem_sc      = (state_q == StMem);
    assign data_addr_o = mem_sc ? mem_addr_q : 32'h0;
    assign data_data_o = (mem_sc && mem_we_q) ? mem_wdata_q : 32'h0;
    assign data_sel_o  = mem_sc ? mem_sel_q : 2'b00;
    assign data_we_o   = mem_sc & mem_we_q;
    assign data_rd_o   = mem_sc & mem_rd_q;
    assign exception   = exc;
    assign cause       = exc_cause;
    assign epc         = exc ? pc_q : 32'h0;

endmodule

// File: tb/tb_core.sv
module tb_core;

    localparam logic [1:0] KNone  = 2'd0;
    localparam logic [1:0] KStore = 2'd1;
    localparam logic [1:0] KLoad  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;      // expected fetch address
        logic [31:0] instr;
        logic [31:0] cause;   // nonzero: exception expected in EXEC
        logic [31:0] cp0in;   // cp0_data_i presented during EXEC
        logic [4:0]  cp0a;    // expected cp0_addr_o
        logic        cp0we;
        logic [31:0] cp0d;    // expected cp0_data_o when cp0we
        logic        eret;
        logic [1:0]  kind;
        logic [31:0] addr;    // expected data_addr_o
        logic [31:0] data;    // expected store data / supplied load data
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_o, inst_data_i;
    logic        inst_valid_i;
    logic [31:0] data_addr_o, data_data_i, data_data_o;
    logic [1:0]  data_sel_o;
    logic        data_we_o, data_rd_o, data_valid_i;
    logic        mem_fc, mem_sc;
    logic        hw_page_fault, hw_interrupt;
    logic [31:0] hw_cause;
    logic        exception;
    logic [31:0] cause, epc;
    logic        eret;
    logic [4:0]  cp0_addr_o;
    logic [31:0] cp0_data_i, cp0_data_o;
    logic        cp0_we_o;
    logic [31:0] cp0_exception_base;

    core dut (
        .clk               (clk),
        .rst               (rst),
        .inst_addr_o       (inst_addr_o),
        .inst_data_i       (inst_data_i),
        .inst_valid_i      (inst_valid_i),
        .data_addr_o       (data_addr_o),
        .data_data_i       (data_data_i),
        .data_data_o       (data_data_o),
        .data_sel_o        (data_sel_o),
        .data_we_o         (data_we_o),
        .data_rd_o         (data_rd_o),
        .data_valid_i      (data_valid_i),
        .mem_fc            (mem_fc),
        .mem_sc            (mem_sc),
        .hw_page_fault     (hw_page_fault),
        .hw_interrupt      (hw_interrupt),
        .hw_cause          (hw_cause),
        .exception         (exception),
        .cause             (cause),
        .epc               (epc),
        .eret              (eret),
        .cp0_addr_o        (cp0_addr_o),
        .cp0_data_i        (cp0_data_i),
        .cp0_data_o        (cp0_data_o),
        .cp0_we_o          (cp0_we_o),
        .cp0_exception_base(cp0_exception_base)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (mem_fc !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check1("fetch_reached", mem_fc, 1'b1);
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [1:0] kind, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] cse);
        vec_t t;
        t       = '0;
        t.pc    = pc;
        t.instr = instr;
        t.kind  = kind;
        t.addr  = addr;
        t.data  = data;
        t.cause = cse;
        return t;
    endfunction

    task automatic step(input vec_t v);
        wait_fetch();
        check("pc", inst_addr_o, v.pc);
        inst_data_i  = v.instr;
        inst_valid_i = 1'b1;
        cp0_data_i   = v.cp0in;
        tick();
        inst_valid_i = 1'b0;
        inst_data_i  = 32'h0;
        check1("exc", exception, v.cause != 32'h0);
        if (v.cause != 32'h0) begin
            check("cause", cause, v.cause);
            check("epc", epc, v.pc);
        end
        check1("eret", eret, v.eret);
        check("cp0_addr", {27'h0, cp0_addr_o}, {27'h0, v.cp0a});
        check1("cp0_we", cp0_we_o, v.cp0we);
        if (v.cp0we) check("cp0_data", cp0_data_o, v.cp0d);
        tick();
        cp0_data_i = 32'h0;
        if (v.kind != KNone) begin
            check1("mem_sc", mem_sc, 1'b1);
            check1("we", data_we_o, v.kind == KStore);
            check1("rd", data_rd_o, v.kind == KLoad);
            check("addr", data_addr_o, v.addr);
            check("sel", {30'h0, data_sel_o}, 32'd2);
            if (v.kind == KStore) check("wdata", data_data_o, v.data);
            tick();
            // Request must still be held while data_valid_i is low.
            check1("hold_sc", mem_sc, 1'b1);
            check("hold_addr", data_addr_o, v.addr);
            data_data_i  = v.data;
            data_valid_i = 1'b1;
            tick();
            data_valid_i = 1'b0;
            data_data_i  = 32'h0;
        end else begin
            check1("no_mem", mem_sc, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t t;
        rst                = 1'b1;
        inst_data_i        = 32'h0;
        inst_valid_i       = 1'b0;
        data_data_i        = 32'h0;
        data_valid_i       = 1'b0;
        hw_page_fault      = 1'b0;
        hw_interrupt       = 1'b0;
        hw_cause           = 32'h0;
        cp0_data_i         = 32'h0;
        cp0_exception_base = 32'h80;

        // Program trace: {pc, instr, kind, addr, data, cause}
        vecs.push_back(mk(32'h00, 32'h24010005, KNone,  32'h0,  32'h0,        32'h0)); // addiu r1,r0,5
        vecs.push_back(mk(32'h04, 32'h00211021, KNone,  32'h0,  32'h0,        32'h0)); // addu r2,r1,r1
        vecs.push_back(mk(32'h08, 32'hAC020000, KStore, 32'h0,  32'd10,       32'h0)); // sw r2,0
        vecs.push_back(mk(32'h0C, 32'h8C030008, KLoad,  32'h8,  32'h8,        32'h0)); // lw r3,8
        vecs.push_back(mk(32'h10, 32'h10000002, KNone,  32'h0,  32'h0,        32'h0)); // beq +2
        vecs.push_back(mk(32'h1C, 32'hAC030004, KStore, 32'h4,  32'h8,        32'h0)); // sw r3,4
        vecs.push_back(mk(32'h20, 32'h0000000C, KNone,  32'h0,  32'h0,        32'd8)); // syscall
        vecs.push_back(mk(32'h80, 32'h3C048000, KNone,  32'h0,  32'h0,        32'h0)); // lui r4
        vecs.push_back(mk(32'h84, 32'h00042903, KNone,  32'h0,  32'h0,        32'h0)); // sra r5,r4,4
        vecs.push_back(mk(32'h88, 32'hAC05000C, KStore, 32'hC,  32'hF8000000, 32'h0)); // sw r5
        vecs.push_back(mk(32'h8C, 32'h00A0302A, KNone,  32'h0,  32'h0,        32'h0)); // slt r6
        vecs.push_back(mk(32'h90, 32'h00A1382B, KNone,  32'h0,  32'h0,        32'h0)); // sltu r7
        vecs.push_back(mk(32'h94, 32'hAC060010, KStore, 32'h10, 32'h1,        32'h0)); // sw r6
        vecs.push_back(mk(32'h98, 32'hAC070014, KStore, 32'h14, 32'h0,        32'h0)); // sw r7
        vecs.push_back(mk(32'h9C, 32'h24000007, KNone,  32'h0,  32'h0,        32'h0)); // addiu r0
        vecs.push_back(mk(32'hA0, 32'hAC000018, KStore, 32'h18, 32'h0,        32'h0)); // sw r0
        vecs.push_back(mk(32'hA4, 32'h8C090002, KNone,  32'h0,  32'h0,        32'd4)); // lw misal
        vecs.push_back(mk(32'h80, 32'h0C000040, KNone,  32'h0,  32'h0,        32'h0)); // jal 0x100
        vecs.push_back(mk(32'h100, 32'hAC1F001C, KStore, 32'h1C, 32'h84,      32'h0)); // sw r31
        t = mk(32'h104, 32'h400A7000, KNone, 32'h0, 32'h0, 32'h0);                    // mfc0 r10,14
        t.cp0in = 32'h200;
        t.cp0a  = 5'd14;
        vecs.push_back(t);
        vecs.push_back(mk(32'h108, 32'h01400008, KNone, 32'h0,  32'h0,        32'h0)); // jr r10
        t = mk(32'h200, 32'h40856000, KNone, 32'h0, 32'h0, 32'h0);                    // mtc0 r5,12
        t.cp0a  = 5'd12;
        t.cp0we = 1'b1;
        t.cp0d  = 32'hF8000000;
        vecs.push_back(t);
        vecs.push_back(mk(32'h204, 32'h14000005, KNone, 32'h0,  32'h0,        32'h0)); // bne nt
        vecs.push_back(mk(32'h208, 32'hFC000000, KNone, 32'h0,  32'h0,        32'd10)); // reserved
        vecs.push_back(mk(32'h80, 32'hAC010002, KNone,  32'h0,  32'h0,        32'd5)); // sw misal
`ifndef CORE_SUBWORD_EN
        vecs.push_back(mk(32'h80, 32'h80010000, KNone,  32'h0,  32'h0,        32'd10)); // lb off
`endif
        vecs.push_back(mk(32'h80, 32'h240C0006, KNone,  32'h0,  32'h0,        32'h0)); // addiu r12
        vecs.push_back(mk(32'h84, 32'h01800008, KNone,  32'h0,  32'h0,        32'd4)); // jr misal

        // Reset state
        tick();
        tick();
        check1("rst_fc", mem_fc, 1'b1);
        check1("rst_we", data_we_o, 1'b0);
        check1("rst_exc", exception, 1'b0);
        check("rst_pc", inst_addr_o, 32'h0);
        rst = 1'b0;
        // Fetch stalls while no instruction is valid.
        tick();
        tick();
        tick();
        check1("stall_fc", mem_fc, 1'b1);
        check("stall_pc", inst_addr_o, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Interrupt between instructions, then ERET back to 0x24.
        wait_fetch();
        check("int_pc", inst_addr_o, 32'h80);
        hw_interrupt = 1'b1;
        hw_cause     = 32'h400;
        #1;
        check1("int_exc", exception, 1'b1);
        check("int_cause", cause, 32'h400);
        check("int_epc", epc, 32'h80);
        tick();
        hw_interrupt = 1'b0;
        hw_cause     = 32'h0;
        t = mk(32'h80, 32'h42000018, KNone, 32'h0, 32'h0, 32'h0);
        t.cp0in = 32'h24;
        t.cp0a  = 5'd14;
        t.eret  = 1'b1;
        step(t);

        // Page fault during a load aborts it: no write to r11.
        wait_fetch();
        check("pf_pc", inst_addr_o, 32'h24);
        inst_data_i  = 32'h8C0B0000; // lw r11,0(r0)
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        tick();
        check1("pf_in_mem", mem_sc, 1'b1);
        hw_page_fault = 1'b1;
        hw_cause      = 32'h77;
        data_data_i   = 32'h55;
        data_valid_i  = 1'b1;
        #1;
        check1("pf_exc", exception, 1'b1);
        check("pf_cause", cause, 32'h77);
        check("pf_epc", epc, 32'h24);
        tick();
        hw_page_fault = 1'b0;
        hw_cause      = 32'h0;
        data_valid_i  = 1'b0;
        data_data_i   = 32'h0;
        step(mk(32'h80, 32'hAC0B0000, KStore, 32'h0, 32'h0, 32'h0)); // sw r11 -> 0

        // Reset in the middle of a store abandons it and clears registers.
        wait_fetch();
        inst_data_i  = 32'hAC010020; // sw r1,32(r0)
        inst_valid_i = 1'b1;
        tick();
        inst_valid_i = 1'b0;
        tick();
        check1("mid_we", data_we_o, 1'b1);
        rst = 1'b1;
        #1;
        check1("mid_rst_we", data_we_o, 1'b0);
        check1("mid_rst_fc", mem_fc, 1'b1);
        check("mid_rst_pc", inst_addr_o, 32'h0);
        tick();
        rst = 1'b0;
        step(mk(32'h0, 32'hAC010000, KStore, 32'h0, 32'h0, 32'h0)); // r1 cleared
        wait_fetch();
        check("final_pc", inst_addr_o, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
